// File: rtl/rdoctrl_lane_arbiter.sv
// Round-robin readout scheduler: grants one lane FIFO at a time and streams its
// words into the shared decoder until the decoder flags an end-of-chip word.
module rdoctrl_lane_arbiter #(
    parameter int NLANES = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   reg_we_i,
    input  logic [7:0]             reg_addr_i,
    input  logic [15:0]            reg_data_i,
    output logic [15:0]            reg_data_o,
    input  logic [24*NLANES-1:0]   lane_data_i,
    input  logic [NLANES-1:0]      lane_empty_i,
    output logic [NLANES-1:0]      lane_re_o,
    output logic [23:0]            dec_data_o,
    output logic                   dec_we_o,
    input  logic                   dec_full_i,
    input  logic                   dec_stopread_i,
    output logic [2:0]             lane_o,
    output logic                   busy_o
);

    localparam int unsigned NL       = NLANES;
    localparam logic [2:0]  LAST_RST = 3'(NLANES - 1);

    typedef enum logic {
        ST_ARB,
        ST_XFER
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        sel_q, last_q, pick;
    logic              found;
    logic [NLANES-1:0] enable_q, cand;
    logic [15:0]       timeout_q, tmo_cnt_q, tmo_cnt_inc;
    logic [15:0]       n_turns_q, n_timeouts_q, n_words_q;
    logic              sel_empty;
    logic [23:0]       sel_word;
    logic              pop, grant, tmo_hit, clear;

    assign busy_o      = (state_q == ST_XFER);
    assign tmo_cnt_inc = tmo_cnt_q + 16'd1;
    assign clear       = reg_we_i && (reg_addr_i == 8'h06);

    // Pick the first enabled, non-empty lane after the last one served.
    // Two passes (above last, then wrapping to 0..last) avoid a modulo index.
    always_comb begin
        cand  = enable_q & ~lane_empty_i;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            if (!found && cand[i] && (i > 32'(last_q))) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
        for (int unsigned i = 0; i < NL; i++) begin
            if (!found && cand[i] && (i <= 32'(last_q))) begin
                found = 1'b1;
                pick  = 3'(i);
            end
        end
    end

    // Mux the granted lane's word and empty flag.
    always_comb begin
        sel_empty = 1'b1;
        sel_word  = '1;
        for (int unsigned k = 0; k < NL; k++) begin
            if (3'(k) == sel_q) begin
                sel_empty = lane_empty_i[k];
                sel_word  = lane_data_i[24*k +: 24];
            end
        end
    end

    // Next-state logic and decoder/FIFO handshake outputs.
    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        grant      = 1'b0;
        tmo_hit    = 1'b0;
        dec_we_o   = 1'b0;
        lane_re_o  = '0;
        dec_data_o = '1;
        case (state_q)
            ST_ARB: begin
                if (found) begin
                    grant   = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                dec_data_o = sel_word;
                pop        = !sel_empty && !dec_full_i;
                dec_we_o   = pop;
                for (int unsigned k = 0; k < NL; k++) begin
                    if (3'(k) == sel_q) lane_re_o[k] = pop;
                end
                if (pop) begin
                    if (dec_stopread_i) state_d = ST_ARB;
                end else if (sel_empty && (timeout_q != 16'd0) && (tmo_cnt_inc == timeout_q)) begin
                    tmo_hit = 1'b1;
                    state_d = ST_ARB;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_ARB;
        else       state_q <= state_d;
    end

    // Grant bookkeeping and the per-turn timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q     <= '0;
            last_q    <= LAST_RST;
            lane_o    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (grant) begin
                sel_q     <= pick;
                last_q    <= pick;
                lane_o    <= pick;
                tmo_cnt_q <= '0;
            end else if (state_q == ST_XFER) begin
                if (pop)            tmo_cnt_q <= '0;
                else if (sel_empty) tmo_cnt_q <= tmo_cnt_inc;
            end
        end
    end

    // Monitoring counters; a CLEAR write wins over a same-cycle increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            n_turns_q    <= '0;
            n_timeouts_q <= '0;
            n_words_q    <= '0;
        end else begin
            if (grant)   n_turns_q    <= n_turns_q + 16'd1;
            if (tmo_hit) n_timeouts_q <= n_timeouts_q + 16'd1;
            if (pop)     n_words_q    <= n_words_q + 16'd1;
        end
    end

    // Writable configuration registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q  <= '1;
            timeout_q <= 16'd256;
        end else if (reg_we_i) begin
            if (reg_addr_i == 8'h01) enable_q  <= reg_data_i[NLANES-1:0];
            if (reg_addr_i == 8'h02) timeout_q <= reg_data_i;
        end
    end

    // Register read mux.
    always_comb begin
        reg_data_o = 16'hF002;
        case (reg_addr_i)
            8'h00:   reg_data_o = {8'b0, busy_o, 4'b0, lane_o};
            8'h01:   reg_data_o = 16'(enable_q);
            8'h02:   reg_data_o = timeout_q;
            8'h03:   reg_data_o = n_turns_q;
            8'h04:   reg_data_o = n_timeouts_q;
            8'h05:   reg_data_o = n_words_q;
            8'h06:   reg_data_o = '0;
            default: reg_data_o = 16'hF002;
        endcase
    end

endmodule

// File: tb/tb_rdoctrl_lane_arbiter.sv
// Directed bench for rdoctrl_lane_arbiter with three modelled lane FIFOs.
`timescale 1ns/1ps
module tb_rdoctrl_lane_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        reg_we_i;
    logic [7:0]  reg_addr_i;
    logic [15:0] reg_data_i;
    logic [15:0] reg_data_o;
    logic [71:0] lane_data_i;
    logic [2:0]  lane_empty_i;
    logic [2:0]  lane_re_o;
    logic [23:0] dec_data_o;
    logic        dec_we_o;
    logic        dec_full_i;
    logic        dec_stopread_i;
    logic [2:0]  lane_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    logic [23:0] q0[$], q1[$], q2[$];
    int          log_lane[$], exp_lane[$];
    logic [23:0] log_word[$], exp_word[$];

    logic        s_we, s_busy;
    logic [2:0]  s_re, s_lane;
    logic [23:0] s_data;

    // End-of-chip marker for this bench: trailer words start with 4'hB.
    assign dec_stopread_i = (dec_data_o[23:20] == 4'hB);

    always #25 clk_i = ~clk_i;

    rdoctrl_lane_arbiter #(.NLANES(3)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .reg_we_i       (reg_we_i),
        .reg_addr_i     (reg_addr_i),
        .reg_data_i     (reg_data_i),
        .reg_data_o     (reg_data_o),
        .lane_data_i    (lane_data_i),
        .lane_empty_i   (lane_empty_i),
        .lane_re_o      (lane_re_o),
        .dec_data_o     (dec_data_o),
        .dec_we_o       (dec_we_o),
        .dec_full_i     (dec_full_i),
        .dec_stopread_i (dec_stopread_i),
        .lane_o         (lane_o),
        .busy_o         (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        lane_empty_i = {q2.size() == 0, q1.size() == 0, q0.size() == 0};
        lane_data_i  = {(q2.size() != 0) ? q2[0] : 24'h0,
                        (q1.size() != 0) ? q1[0] : 24'h0,
                        (q0.size() != 0) ? q0[0] : 24'h0};
    endtask

    // One clock: sample outputs mid-cycle, log pops, then apply them to the FIFOs.
    task automatic tick();
        @(negedge clk_i);
        s_we   = dec_we_o;
        s_re   = lane_re_o;
        s_data = dec_data_o;
        s_busy = busy_o;
        s_lane = lane_o;
        check_eq("re_matches_we", 32'(s_re), s_we ? (32'd1 << s_lane) : 32'd0);
        if (s_we) begin
            log_lane.push_back(int'(s_lane));
            log_word.push_back(s_data);
        end
        @(posedge clk_i);
        #1;
        if (s_re[0] && q0.size() != 0) void'(q0.pop_front());
        if (s_re[1] && q1.size() != 0) void'(q1.pop_front());
        if (s_re[2] && q2.size() != 0) void'(q2.pop_front());
        refresh();
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        reg_we_i   = 1'b1;
        reg_addr_i = a;
        reg_data_i = d;
        tick();
        reg_we_i   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [15:0] exp);
        reg_addr_i = a;
        #1;
        check_eq(tag, 32'(reg_data_o), 32'(exp));
    endtask

    task automatic expect_pop(input int lane, input logic [23:0] w);
        exp_lane.push_back(lane);
        exp_word.push_back(w);
    endtask

    task automatic start_log();
        log_lane.delete();
        log_word.delete();
        exp_lane.delete();
        exp_word.delete();
    endtask

    task automatic check_log(input string tag);
        check_eq({tag, "_pop_count"}, 32'(log_lane.size()), 32'(exp_lane.size()));
        for (int i = 0; i < exp_lane.size() && i < log_lane.size(); i++) begin
            check_eq({tag, "_pop_lane"}, 32'(log_lane[i]), 32'(exp_lane[i]));
            check_eq({tag, "_pop_word"}, 32'(log_word[i]), 32'(exp_word[i]));
        end
    endtask

    task automatic load_std(input int lane);
        logic [23:0] hdr, dat;
        hdr = 24'hA000FF | (24'(lane) << 8);
        dat = 24'h000000 | (24'(lane) << 8);
        case (lane)
            0: begin q0.push_back(hdr); q0.push_back(dat); q0.push_back(24'hB0FFFF); end
            1: begin q1.push_back(hdr); q1.push_back(dat); q1.push_back(24'hB0FFFF); end
            default: begin q2.push_back(hdr); q2.push_back(dat); q2.push_back(24'hB0FFFF); end
        endcase
    endtask

    initial begin
        rst_i      = 1'b1;
        reg_we_i   = 1'b0;
        reg_addr_i = 8'h00;
        reg_data_i = 16'h0;
        dec_full_i = 1'b0;
        refresh();
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        check_eq("rst_dec_we", 32'(dec_we_o), 32'd0);
        check_eq("rst_dec_data", 32'(dec_data_o), 32'hFFFFFF);
        check_eq("rst_lane_re", 32'(lane_re_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        rd("rst_status", 8'h00, 16'h0000);
        rd("rst_enable", 8'h01, 16'h0007);
        rd("rst_timeout", 8'h02, 16'd256);
        rd("rst_n_turns", 8'h03, 16'h0000);
        rd("rst_undef_addr", 8'h20, 16'hF002);

        // Round robin: three full chips, served 0,1,2 without interleaving
        start_log();
        for (int l = 0; l < 3; l++) begin
            load_std(l);
            expect_pop(l, 24'hA000FF | (24'(l) << 8));
            expect_pop(l, 24'h000000 | (24'(l) << 8));
            expect_pop(l, 24'hB0FFFF);
        end
        refresh();
        tick();
        check_eq("rr_grant_cycle_idle", 32'(s_busy), 32'd0);
        tick();
        check_eq("rr_first_pop", 32'(s_we), 32'd1);
        repeat (14) tick();
        check_log("rr");
        rd("rr_n_turns", 8'h03, 16'd3);
        rd("rr_n_words", 8'h05, 16'd9);

        // Backpressure: decoder full for 10 cycles mid-turn, lane not empty
        wr(8'h06, 16'h0);
        wr(8'h02, 16'd4);
        start_log();
        q0.push_back(24'hA000FF); q0.push_back(24'h000000);
        q0.push_back(24'h000001); q0.push_back(24'hB0FFFF);
        expect_pop(0, 24'hA000FF); expect_pop(0, 24'h000000);
        expect_pop(0, 24'h000001); expect_pop(0, 24'hB0FFFF);
        refresh();
        tick();
        tick();
        dec_full_i = 1'b1;
        repeat (10) tick();
        check_eq("bp_no_pops", 32'(log_lane.size()), 32'd1);
        check_eq("bp_still_busy", 32'(s_busy), 32'd1);
        check_eq("bp_held_word", 32'(s_data), 32'h000000);
        rd("bp_no_timeout", 8'h04, 16'd0);
        dec_full_i = 1'b0;
        repeat (6) tick();
        check_log("bp");
        rd("bp_n_words", 8'h05, 16'd4);
        rd("bp_n_turns", 8'h03, 16'd1);

        // Timeout: lane 1 sends only a header, TIMEOUT=4
        wr(8'h06, 16'h0);
        start_log();
        q1.push_back(24'hA001FF);
        q2.push_back(24'hA002FF); q2.push_back(24'hB0FFFF);
        expect_pop(1, 24'hA001FF); expect_pop(2, 24'hA002FF); expect_pop(2, 24'hB0FFFF);
        refresh();
        tick();
        tick();
        check_eq("tmo_hdr_pop_lane", 32'(s_lane), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("tmo_waiting_busy", 32'(s_busy), 32'd1);
        end
        tick();
        check_eq("tmo_arb_after_5", 32'(s_busy), 32'd0);
        tick();
        check_eq("tmo_next_lane", 32'(s_lane), 32'd2);
        repeat (4) tick();
        check_log("tmo");
        rd("tmo_n_timeouts", 8'h04, 16'd1);
        rd("tmo_n_turns", 8'h03, 16'd2);
        rd("tmo_n_words", 8'h05, 16'd3);

        // Enable mask 3'b101; disabling lane 2 mid-turn lets the turn finish
        wr(8'h01, 16'h0005);
        start_log();
        load_std(0);
        load_std(1);
        q2.push_back(24'hA002FF); q2.push_back(24'h000200);
        q2.push_back(24'h000201); q2.push_back(24'hB0FFFF);
        expect_pop(0, 24'hA000FF); expect_pop(0, 24'h000000); expect_pop(0, 24'hB0FFFF);
        expect_pop(2, 24'hA002FF); expect_pop(2, 24'h000200);
        expect_pop(2, 24'h000201); expect_pop(2, 24'hB0FFFF);
        refresh();
        repeat (6) tick();
        wr(8'h01, 16'h0001);
        repeat (8) tick();
        check_log("en");
        check_eq("en_lane1_untouched", 32'(q1.size()), 32'd3);
        check_eq("en_idle_after", 32'(s_busy), 32'd0);
        rd("en_readback", 8'h01, 16'h0001);
        q1.delete();
        refresh();
        wr(8'h01, 16'h0007);

        // Reset mid-turn (decoder full so the reset cycle pops nothing)
        start_log();
        load_std(0);
        refresh();
        tick();
        tick();
        rst_i      = 1'b1;
        dec_full_i = 1'b1;
        tick();
        rst_i      = 1'b0;
        dec_full_i = 1'b0;
        check_eq("mrst_dec_we", 32'(dec_we_o), 32'd0);
        check_eq("mrst_dec_data", 32'(dec_data_o), 32'hFFFFFF);
        check_eq("mrst_fifo_kept", 32'(q0.size()), 32'd2);
        rd("mrst_status", 8'h00, 16'h0000);
        rd("mrst_n_turns", 8'h03, 16'd0);
        rd("mrst_n_timeouts", 8'h04, 16'd0);
        rd("mrst_n_words", 8'h05, 16'd0);
        rd("mrst_enable", 8'h01, 16'h0007);
        rd("mrst_timeout", 8'h02, 16'd256);
        rd("mrst_undef_addr", 8'h20, 16'hF002);

        // CLEAR write in the same cycle as a pop
        tick();
        wr(8'h06, 16'h0);
        check_eq("clr_pop_happened", 32'(s_we), 32'd1);
        rd("clr_n_words", 8'h05, 16'd0);
        rd("clr_n_turns", 8'h03, 16'd0);
        tick();
        tick();
        rd("clr_n_words_after", 8'h05, 16'd1);
        check_eq("clr_fifo_drained", 32'(q0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
